// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman serial link.
// Used by uart_tx and the planned uart_rx.
package hangman_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } uart_tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 100;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Request/status bundle between the message register and uart_tx.
// master = message register side, slave = transmitter side.
interface uart_tx_if
    import hangman_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);
    logic                 tx_ctrl;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 transmit_ready;
    logic                 tx_serial;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_ctrl, tx_byte,
        input  transmit_ready, tx_serial, tx_busy, tx_done
    );

    modport slave (
        input  tx_ctrl, tx_byte,
        output transmit_ready, tx_serial, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// tick_o marks the terminal count; the counter wraps there.
module baud_tick
    import hangman_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    localparam int CW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          clear_i,
    input  logic          en_i,
    output logic          tick_o,
    output logic [CW-1:0] count_o
);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o  = en_i && (cnt_q == TERM);
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, data LSB first, stop bit.
// Every output is a register computed from next-state values.
module uart_tx
    import hangman_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic      clk,
    input  logic      nRst,
    uart_tx_if.slave  tx_if
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 serial_q, serial_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic          baud_clr;
    logic          baud_en;
    logic          tick;
    logic [CW-1:0] baud_cnt;

    assign baud_clr = (state_q == TX_IDLE);
    assign baud_en  = (state_q != TX_IDLE);

    baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .nRst    (nRst),
        .clear_i (baud_clr),
        .en_i    (baud_en),
        .tick_o  (tick),
        .count_o (baud_cnt)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (tx_if.tx_ctrl) begin
                    state_d = TX_START;
                    shift_d = tx_if.tx_byte;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_d = TX_DATA;
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                // one cycle early so the registered pulse lands on the last stop cycle
                done_d = (baud_cnt == PRE);
                if (tick) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        serial_d = 1'b1;
        if (state_d == TX_START) begin
            serial_d = 1'b0;
        end else if (state_d == TX_DATA) begin
            serial_d = shift_d[0];
        end
        ready_d = (state_d == TX_IDLE);
        busy_d  = (state_d != TX_IDLE);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= TX_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_if.tx_serial      = serial_q;
    assign tx_if.transmit_ready = ready_q;
    assign tx_if.tx_busy        = busy_q;
    assign tx_if.tx_done        = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed frame checks at 4 clks/bit plus a mid-bit decoder
// scoreboard on three more instances (2, 5, 16 clks/bit).
module tb_uart_tx;
    localparam int NB = 200;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    bit   sb_go = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) tif ();

    uart_tx #(
        .CLKS_PER_BIT (4),
        .DATA_BITS    (8)
    ) u_dut (
        .clk   (clk),
        .nRst  (nRst),
        .tx_if (tif)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int p);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    // One frame from accept; optional ignored request at cycle pulse_at.
    task automatic frame(input string tag, input logic [7:0] b,
                         input int pulse_at);
        logic [41:0] ln, dn, rd, bz;
        ln = '0; dn = '0; rd = '0; bz = '0;
        @(negedge clk);
        check({tag, "_rdy_pre"}, tif.transmit_ready, 1);
        tif.tx_byte = b;
        tif.tx_ctrl = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            tif.tx_ctrl = (c == pulse_at);
            tif.tx_byte = (c == pulse_at) ? 8'h00 : ~b;
            ln[c] = tif.tx_serial;
            dn[c] = tif.tx_done;
            rd[c] = tif.transmit_ready;
            bz[c] = tif.tx_busy;
        end
        for (int p = 0; p < 10; p++) begin
            check($sformatf("%s_period%0d", tag, p), ln[4*p+1 +: 4],
                  {4{exp_bit(b, p)}});
        end
        check({tag, "_busy1"}, bz[1], 1);
        check({tag, "_done39"}, dn[39], 0);
        check({tag, "_done40"}, dn[40], 1);
        check({tag, "_rdy40"}, rd[40], 0);
        check({tag, "_rdy41"}, rd[41], 1);
        check({tag, "_busy41"}, bz[41], 0);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sb
        localparam int CPB = (g == 0) ? 2 : (g == 1) ? 5 : 16;
        uart_tx_if #(.DATA_BITS(8)) sif ();
        uart_tx #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (8)
        ) u_sb (
            .clk   (clk),
            .nRst  (nRst),
            .tx_if (sif)
        );
        logic [7:0] q[$];
        bit fin = 1'b0;
        int ndone = 0;
        int bad = 0;

        always @(negedge clk) begin
            if (sb_go && sif.tx_done) ndone++;
            if (sb_go && (sif.tx_busy == sif.transmit_ready)) bad++;
        end

        initial begin
            logic [7:0] b;
            int t;
            sif.tx_ctrl = 1'b0;
            sif.tx_byte = 8'h00;
            wait (sb_go);
            for (int n = 0; n < NB; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                t = 0;
                while (!sif.transmit_ready && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 500) begin
                    check($sformatf("sb%0d_ready_timeout", CPB), 0, 1);
                    break;
                end
                b = 8'($urandom);
                sif.tx_byte = b;
                sif.tx_ctrl = 1'b1;
                q.push_back(b);
                @(negedge clk);
                sif.tx_ctrl = 1'b0;
                sif.tx_byte = 8'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    sif.tx_ctrl = 1'b1;
                    sif.tx_byte = 8'($urandom);
                    @(negedge clk);
                    sif.tx_ctrl = 1'b0;
                end
            end
        end

        initial begin
            logic [7:0] d, e;
            logic st, sp;
            int t;
            wait (sb_go);
            for (int n = 0; n < NB; n++) begin
                t = 0;
                @(negedge clk);
                while (sif.tx_serial !== 1'b0 && t < 400) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 400) begin
                    check($sformatf("sb%0d_start_timeout", CPB), 0, 1);
                    break;
                end
                repeat (CPB / 2) @(negedge clk);
                st = sif.tx_serial;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = sif.tx_serial;
                end
                repeat (CPB) @(negedge clk);
                sp = sif.tx_serial;
                e = (q.size() != 0) ? q.pop_front() : ~d;
                check($sformatf("sb%0d_byte%0d", CPB, n), {st, sp, d},
                      {1'b0, 1'b1, e});
            end
            repeat (CPB + 2) @(negedge clk);
            check($sformatf("sb%0d_done_count", CPB), ndone, NB);
            check($sformatf("sb%0d_busy_in_idle", CPB), bad, 0);
            fin = 1'b1;
        end
    end

    initial begin
        logic [82:0] l4, r4;
        logic stays;
        int t;
        tif.tx_ctrl = 1'b0;
        tif.tx_byte = 8'h00;
        l4 = '0;
        r4 = '0;

        repeat (3) @(negedge clk);
        check("rst_serial", tif.tx_serial, 1);
        check("rst_ready", tif.transmit_ready, 1);
        check("rst_busy", tif.tx_busy, 0);
        check("rst_done", tif.tx_done, 0);
        nRst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_serial", tif.tx_serial, 1);
        check("idle_ready", tif.transmit_ready, 1);
        check("idle_busy", tif.tx_busy, 0);

        frame("t2_A5", 8'hA5, 0);

        frame("t3_3C", 8'h3C, 20);
        stays = 1'b1;
        repeat (12) begin
            @(negedge clk);
            stays = stays & tif.tx_serial & tif.transmit_ready;
        end
        check("t3_no_second_frame", stays, 1);

        @(negedge clk);
        tif.tx_byte = 8'hFF;
        tif.tx_ctrl = 1'b1;
        for (int c = 1; c <= 82; c++) begin
            @(negedge clk);
            if (c == 1) tif.tx_byte = 8'h00;
            if (c == 42) tif.tx_ctrl = 1'b0;
            l4[c] = tif.tx_serial;
            r4[c] = tif.transmit_ready;
        end
        check("t4_f1_start", l4[4:1], 4'h0);
        check("t4_f1_body", &l4[40:5], 1);
        check("t4_gap_line", l4[41], 1);
        check("t4_gap_ready", r4[41], 1);
        check("t4_f2_start", l4[45:42], 4'h0);
        check("t4_f2_data", |l4[77:46], 0);
        check("t4_f2_stop", &l4[81:78], 1);
        check("t4_ready_after", r4[82], 1);

        @(negedge clk);
        tif.tx_byte = 8'hF0;
        tif.tx_ctrl = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) tif.tx_ctrl = 1'b0;
        end
        check("t5_bit3_low", tif.tx_serial, 0);
        check("t5_busy_pre", tif.tx_busy, 1);
        nRst = 1'b0;
        #1;
        check("t5_rst_serial", tif.tx_serial, 1);
        check("t5_rst_ready", tif.transmit_ready, 1);
        check("t5_rst_busy", tif.tx_busy, 0);
        @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        frame("t5_5A", 8'h5A, 0);

        sb_go = 1'b1;
        t = 0;
        while (!(g_sb[0].fin && g_sb[1].fin && g_sb[2].fin) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        check("sb_finish_in_time", t < 60000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
